// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side definitions: transmitter states, frame size and
// default cycle counts for the 65 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    // Data bits + parity + stop; the start bit is driven during RTS.
    localparam int FRAME_BITS = 10;

    localparam int DEF_INHIBIT_CYCLES = 6500;
    localparam int DEF_TIMEOUT_CYCLES = 975000;
    localparam int DEF_FILTER_LEN     = 8;

    // Frame as shifted out LSB first: {stop, odd parity, data}.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-stage synchronizer plus run-length glitch filter for one open-drain
// PS/2 line; emits the filtered level and a one-cycle falling-edge strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= 2'b11;
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            fall_reg <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync_reg[1];
                cnt_reg   <= '0;
                fall_reg  <= level_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// one command byte out on device clock edges and checks the acknowledge.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST      = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST       = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT_IDX  = 4'(FRAME_BITS - 1);

    tx_state_t             state_reg;
    logic [INH_W-1:0]      inh_cnt_reg;
    logic [WD_W-1:0]       wd_cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  ack_ok_reg;
    logic                  clk_oe_reg;
    logic                  data_oe_reg;
    logic                  tx_ready_reg;
    logic                  busy_reg;
    logic                  tx_done_reg;
    logic                  tx_err_reg;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;
    logic in_frame;
    logic wd_expired;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_clk_i),
        .level(clk_level),
        .fall (clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_data_i),
        .level(data_level),
        .fall (data_fall_unused)
    );

    // The device owns the clock from SEND onwards; a silent device must not hang us.
    assign in_frame   = (state_reg == SEND) || (state_reg == ACK) || (state_reg == WAIT_IDLE);
    assign wd_expired = in_frame && !clk_fall && (wd_cnt_reg == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            inh_cnt_reg  <= '0;
            wd_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ack_ok_reg   <= 1'b0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            tx_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            tx_done_reg  <= 1'b0;
            tx_err_reg   <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            tx_err_reg  <= 1'b0;

            if (in_frame) begin
                wd_cnt_reg <= clk_fall ? '0 : wd_cnt_reg + 1'b1;
            end

            if (wd_expired) begin
                state_reg    <= IDLE;
                clk_oe_reg   <= 1'b0;
                data_oe_reg  <= 1'b0;
                tx_err_reg   <= 1'b1;
                tx_ready_reg <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        clk_oe_reg   <= 1'b0;
                        data_oe_reg  <= 1'b0;
                        busy_reg     <= 1'b0;
                        tx_ready_reg <= 1'b1;
                        if (tx_valid && tx_ready_reg) begin
                            shift_reg    <= build_frame(tx_data);
                            inh_cnt_reg  <= '0;
                            bit_cnt_reg  <= '0;
                            ack_ok_reg   <= 1'b0;
                            clk_oe_reg   <= 1'b1;
                            tx_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            state_reg    <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (inh_cnt_reg == INH_LAST) begin
                            data_oe_reg <= 1'b1;
                            state_reg   <= RTS;
                        end else begin
                            inh_cnt_reg <= inh_cnt_reg + 1'b1;
                        end
                    end

                    RTS: begin
                        clk_oe_reg <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= SEND;
                    end

                    SEND: begin
                        if (clk_fall) begin
                            data_oe_reg <= ~shift_reg[0];
                            shift_reg   <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == LAST_BIT_IDX) begin
                                state_reg <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        if (clk_fall) begin
                            ack_ok_reg <= ~data_level;
                            state_reg  <= WAIT_IDLE;
                        end
                    end

                    WAIT_IDLE: begin
                        if (clk_level && data_level) begin
                            tx_done_reg  <= ack_ok_reg;
                            tx_err_reg   <= ~ack_ok_reg;
                            tx_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end

                    default: begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_reg;
    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign tx_done     = tx_done_reg;
    assign tx_err      = tx_err_reg;

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain clock/data pair the receive path listens on.
- Frame sequence: clock inhibit, request-to-send, 11 device-clocked bits, acknowledge check.
- Sits in the 65 MHz domain beside the PS/2 receiver. The top level maps the open-drain enables onto tri-state pads.

Parameters:
INHIBIT_CYCLES, 6500, cycles ps2 clock is held low before request-to-send (100 us at 65 MHz)
TIMEOUT_CYCLES, 975000, max cycles between filtered falling edges before abort (15 ms)
FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a new line level

Ports:
clk  input  1  system clock (65 MHz)
rst  input  1  asynchronous active-high reset
tx_data  input  8  command byte
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid & tx_ready
ps2_clk_i  input  1  raw ps2 clock pad level
ps2_data_i  input  1  raw ps2 data pad level
ps2_clk_oe  output  1  1 = drive ps2 clock low, 0 = release
ps2_data_oe  output  1  1 = drive ps2 data low, 0 = release
busy  output  1  high from accept until return to IDLE; the receive path ignores frames while high
tx_done  output  1  one-cycle pulse: byte acknowledged by device
tx_err  output  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (async) values:
  - ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0 during reset (1 in IDLE afterwards), busy=0, tx_done=0, tx_err=0.
  - State IDLE, all counters 0, filtered lines = 1.
- Reset asserted mid-frame: both lines are released immediately; no done/err pulse.
- Input conditioning:
  - 2-FF synchronizer per line, then glitch filter: filtered level changes only after FILTER_LEN identical samples.
  - fall = filtered clk 1->0, one-cycle strobe.
- Accept: tx_valid & tx_ready latches tx_data into the shift register.
  - Parity = ~^tx_data (odd).
  - Frame = {stop=1, parity, data[7:0]}, shifted LSB first.
  - tx_valid is ignored outside IDLE.
- States:
  - IDLE:
    - tx_ready=1, oe both 0.
    - On accept -> INHIBIT next cycle.
    - The host has priority: a device frame in progress is aborted by the inhibit.
  - INHIBIT:
    - clk_oe=1 for exactly INHIBIT_CYCLES cycles, then -> RTS.
  - RTS:
    - data_oe=1 (start bit 0) and clk_oe=1 for one cycle, then clk_oe=0 -> SEND.
    - Watchdog cleared.
  - SEND:
    - On each fall: data_oe = ~frame[bit_cnt], bit_cnt++.
    - Fall 1..8 drive d0..d7; fall 9 drives parity; fall 10 drives stop (data released).
    - After fall 10 -> ACK.
  - ACK:
    - On fall 11, sample filtered data.
    - data 0 -> ack_ok=1; data 1 -> ack_ok=0.
    - -> WAIT_IDLE.
  - WAIT_IDLE:
    - Wait until filtered clk=1 and data=1.
    - Then pulse tx_done (ack_ok) or tx_err (!ack_ok) and -> IDLE.
    - The pulse and tx_ready=1 occur in the same cycle.
- Watchdog:
  - In SEND/ACK/WAIT_IDLE, the counter increments each cycle and clears on fall.
  - Reaching TIMEOUT_CYCLES -> release both lines, tx_err pulse, -> IDLE.
- busy=1 in every state except IDLE.
- tx_done and tx_err are never asserted together.
- Counter widths: $clog2 of the respective parameter + 1; bit_cnt is 4 bits.

Decomposition:
- ps2_pkg holds:
  - the tx state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE)
  - FRAME_BITS=10
  - default cycle constants for 65 MHz
- Sub-module ps2_line_filter (2-FF sync + FILTER_LEN filter + fall strobe) is instantiated once per line; the receiver path can reuse it.

Test Plan:
- Bench setup: parameters INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4. A device model clocks with a 40-cycle period and samples data on rising edges.
- Send 0xED -> clk held low exactly 20 cycles, then start 0. Bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> tx_done pulse once, tx_ready back to 1.
- Send 0xF4 -> parity sampled 0. Send 0x00 -> parity 1. Data bits match LSB-first on each device rising edge.
- Device leaves data high at clock 11 (NACK) -> tx_err single pulse, no tx_done, lines released, IDLE.
- Device stops clocking after 5 bits -> tx_err after 2000 idle cycles, both oe=0, tx_ready=1. A following 0xFF frame then completes with tx_done.
- Assert rst during SEND bit 4 -> oe outputs 0 in the same cycle (async), no pulses. tx_valid held during busy is not re-accepted until IDLE.
- Glitch of 2 cycles low on ps2_clk_i during SEND -> no bit advance. A 4-cycle low pulse is counted as an edge.
